// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM encoding and
// the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Guarded so a degenerate width still yields a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fac.sv
// Single-bit full adder cell shared by the serial adder; purely combinational.
module fac (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic z,
    output logic co
);

    assign z  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: one fac cell time-shared over W cycles, LSB first,
// with a start/ready/done handshake and a result held between completions.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    // state   | meaning
    // ST_IDLE | waiting for start, ready
    // ST_RUN  | one bit per edge through fac, busy
    // ST_DONE | result just written, done pulse, ready (back-to-back start ok)
    state_e        state_q;
    logic [W-1:0]  a_sh_q;
    logic [W-1:0]  b_sh_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;

    logic          fac_z;
    logic          fac_co;

    fac u_fac (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .z  (fac_z),
        .co (fac_co)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    acc_q   <= {fac_z, acc_q[W-1:1]};
                    carry_q <= fac_co;
                    cnt_q   <= cnt_q + 1'b1;
                    // Final bit goes straight into the result, not via acc.
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= {fac_z, acc_q[W-1:1]};
                        cout_q  <= fac_co;
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: W=8 handshake/timing cases plus an
// exhaustive W=4 sweep, all expectations hand-computed.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, ready4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.W(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .ready_o(ready8), .busy_o(busy8), .done_o(done8),
        .sum_o(sum8), .cout_o(cout8)
    );

    serial_adder_ctrl #(.W(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
        .cin_i(cin4), .ready_o(ready4), .busy_o(busy4), .done_o(done4),
        .sum_o(sum4), .cout_o(cout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation, watch the run, leave the bench in the DONE cycle.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] prev_sum, input logic prev_cout,
                       input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        int nbusy;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk({tag, "_busy0"}, busy8, 1);
        chk({tag, "_ready0"}, ready8, 0);
        chk({tag, "_sum_hold"}, sum8, prev_sum);
        chk({tag, "_cout_hold"}, cout8, prev_cout);
        n = 0; nbusy = 0;
        while (!done8 && n < 20) begin
            if (busy8) nbusy++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_busy_cycles"}, nbusy, 8);
        chk({tag, "_done_ready"}, ready8, 1);
        chk({tag, "_sum"}, sum8, exp_sum);
        chk({tag, "_cout"}, cout8, exp_cout);
    endtask

    initial begin
        int n;
        logic [4:0] exp5;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #12;
        chk("rst_ready", ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        tick();
        rst_n = 1'b1;
        tick();

        op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        chk("ff_01_done_pulse", done8, 0);
        chk("ff_01_idle_ready", ready8, 1);
        chk("ff_01_idle_busy", busy8, 0);
        chk("ff_01_idle_sum", sum8, 8'h00);
        chk("ff_01_idle_cout", cout8, 1);

        op8("5a_33", 8'h5A, 8'h33, 1'b1, 8'h00, 1'b1, 8'h8E, 1'b0);
        tick();
        op8("55_aa", 8'h55, 8'hAA, 1'b1, 8'h8E, 1'b0, 8'h00, 1'b1);
        tick();

        // start held high and operands changed while running
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        n = 0;
        repeat (4) begin
            tick();
            n++;
        end
        chk("hold_busy_mid", busy8, 1);
        start8 = 1'b0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk("hold_latency", n, 8);
        chk("hold_sum", sum8, 8'h46);
        chk("hold_cout", cout8, 0);
        tick();
        chk("hold_idle", busy8, 0);

        // back-to-back: second start issued in the DONE cycle
        op8("b2b_1", 8'h21, 8'h03, 1'b0, 8'h46, 1'b0, 8'h24, 1'b0);
        op8("b2b_2", 8'h10, 8'h20, 1'b0, 8'h24, 1'b0, 8'h30, 1'b0);
        tick();

        // reset in the 4th cycle of RUN
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        chk("rst_mid_busy_before", busy8, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", ready8, 1);
        chk("rst_mid_busy", busy8, 0);
        chk("rst_mid_sum", sum8, 0);
        chk("rst_mid_cout", cout8, 0);
        repeat (2) begin
            tick();
            chk("rst_mid_no_done", done8, 0);
        end
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            chk("rst_mid_no_done_after", done8, 0);
        end
        op8("after_rst", 8'h0F, 8'h01, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0);
        tick();

        // exhaustive W=4, issued back-to-back
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    n = 0;
                    while (!done4 && n < 10) begin
                        tick();
                        n++;
                    end
                    exp5 = 5'(ia + ib + ic);
                    chk($sformatf("w4_%0h_%0h_%0d", ia, ib, ic), {cout4, sum4}, exp5);
                end
            end
        end
        chk("w4_last_latency", n, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial W-bit adder controller that sequences a single `fac` cell over W clock cycles to produce `a + b + cin`. The block owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. It is the area-minimal alternative to a W-wide ripple adder for the team's arithmetic datapath: one full adder is time-shared across all bit positions.

## Interface
- `W`, default 8: operand width, W >= 2; the counter width is $clog2(W).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new addition; sampled only while `ready`=1.
- `a` input W: operand A; captured on the accepted start edge.
- `b` input W: operand B; captured on the accepted start edge.
- `cin` input 1: carry-in; captured on the accepted start edge.
- `ready` output 1: block can accept `start` (state IDLE or DONE).
- `busy` output 1: addition in progress (state RUN).
- `done` output 1: one-cycle pulse; `sum`/`cout` just updated.
- `sum` output W: registered result; stable between completions.
- `cout` output 1: registered carry-out of the MSB.

## Operation
- FSM states are IDLE, RUN and DONE. Encoding lives in the package.
- IDLE: `ready`=1. On `start`=1, load `a_sh`←a, `b_sh`←b, `carry`←cin, `cnt`←0, `acc`←0, then go to RUN.
- RUN: `busy`=1 and `ready`=0. `fac` inputs are x=`a_sh[0]`, y=`b_sh[0]`, ci=`carry`. Each edge does the following:
  - `a_sh`, `b_sh` shift right by 1.
  - `acc` ← {z, acc[W-1:1]}.
  - `carry` ← co.
  - `cnt` increments.
- RUN exit: on the edge where `cnt`==W-1, load `sum` ← {z, acc[W-1:1]} and `cout` ← co, then go to DONE.
- DONE: `done`=1 and `ready`=1.
  - `start`=1 in DONE: accepted exactly as in IDLE (back-to-back operation); next state is RUN.
  - Otherwise the next state is IDLE.
- `start` while RUN: ignored, with no effect on operands or progress.
- `sum` and `cout` change only on the RUN→DONE edge. They hold through IDLE and through the whole next RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). No overflow flag.
- Reset (any time, including mid-RUN): state←IDLE, sum←0, cout←0, shift registers/carry/cnt←0. Outputs are `ready`=1, `busy`=0, `done`=0. The in-flight operation is discarded.

## Timing
- Accept edge E0 (start=1, ready=1).
- `busy`=1 from E0 to EW, which is W cycles.
- Bit i is processed on edge E(i+1).
- `done`=1 for exactly the cycle between EW and EW+1. Result valid from EW.
- Latency is W cycles from start edge to done. Throughput is one addition per W cycles when back-to-back.
- `ready`, `busy` and `done` are decoded from registered state only (Moore), with no combinational path from `start`.
- `fac` is purely combinational between registers. The critical path is carry FF → fac → carry FF.

## Structure
- Package `serial_adder_pkg`: state typedef (IDLE, RUN, DONE) and localparam counter-width helper.
- Sub-module: one instance of the existing `fac` cell, unchanged. No other hierarchy.
- Expected RTL size is roughly 120–180 lines.

## Test plan
- W=8: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1; `done` exactly 8 cycles after the start edge; `busy`=1 for 8 cycles.
- W=8: a=8'h5A, b=8'h33, cin=1 → sum=8'h8E, cout=0. Then a=8'h55, b=8'hAA, cin=1 → sum=8'h00, cout=1.
- Start held high during RUN, with a/b changed mid-run → result uses operands from the accept edge only; no restart.
- Back-to-back: start=1 in the DONE cycle with a=8'h10, b=8'h20, cin=0 → second `done` 8 cycles later, sum=8'h30. `sum` holds the first result until then.
- Assert rst_n=0 on cycle 4 of RUN → immediately ready=1, busy=0, sum=0, cout=0, no `done` pulse. A subsequent start completes correctly.
- W=4 exhaustive: all 512 (a,b,cin) combinations, with {cout,sum} checked against a+b+cin each `done`.
